// File: rtl/pga.sv
// pga - packet generator analyzer (egress end of the pgm test path).
//
// Classifies each incoming packet by its head word. A head carrying TAG in
// data[127:112] is a generated test packet. Test packets are absorbed, and
// their sequence number and one-way latency are checked. All other traffic
// is forwarded unchanged with exactly one cycle of delay.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_pga_data[133:0]    [133:132] 01 head / 11 body / 10 tail,
//                         [131:128] invalid bytes, [127:0] payload
//   in_pga_data_wr        data word strobe
//   in_pga_valid_wr       end-of-packet strobe (with the tail word)
//   in_pga_valid          1 = packet good, 0 = discard
//   out_pga_alf           almost-full to upstream (mirrors in_pga_alf)
//   in_pga_timestamp      free-running cycle counter shared with pgm
//   in_pga_start_flag     pgm start pulse, clears the statistics
//   out_pga_data/_data_wr/_valid_wr/_valid   forwarded non-test traffic
//   in_pga_alf            downstream almost-full
//   out_pga_pkt_cnt       good test packets received (saturating)
//   out_pga_err_cnt       sequence errors + bad test packets (saturating)
//   out_pga_last_lat      latency of the most recent good test packet
//   out_pga_max_lat       maximum latency since the last clear
module pga #(
    parameter logic [15:0] TAG  = 16'hFA57,
    parameter logic [7:0]  LMID = 8'd7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in_pga_data,
    input  logic         in_pga_data_wr,
    input  logic         in_pga_valid_wr,
    input  logic         in_pga_valid,
    output logic         out_pga_alf,
    input  logic [31:0]  in_pga_timestamp,
    input  logic         in_pga_start_flag,
    output logic [133:0] out_pga_data,
    output logic         out_pga_data_wr,
    output logic         out_pga_valid_wr,
    output logic         out_pga_valid,
    input  logic         in_pga_alf,
    output logic [31:0]  out_pga_pkt_cnt,
    output logic [31:0]  out_pga_err_cnt,
    output logic [31:0]  out_pga_last_lat,
    output logic [31:0]  out_pga_max_lat
);

    typedef enum logic [1:0] {IDLE, FWD, CHK} state_t;

    state_t      state;
    logic [31:0] seq_q;
    logic [31:0] ts_q;
    logic [31:0] exp_seq;

    logic        head;
    logic        is_tag;
    logic        fin;
    logic [31:0] fin_seq;
    logic [31:0] fin_ts;
    logic [31:0] lat;

    assign out_pga_alf = in_pga_alf;

    assign head   = in_pga_data_wr && (in_pga_data[133:132] == 2'b01);
    assign is_tag = (in_pga_data[127:112] == TAG);

    // End of a test packet. A single-word test packet finalizes in IDLE, so
    // its seq/timestamp come straight from the head word instead of the latch.
    always_comb begin
        fin     = 1'b0;
        fin_seq = seq_q;
        fin_ts  = ts_q;
        case (state)
            IDLE: begin
                if (head && is_tag && in_pga_valid_wr) begin
                    fin     = 1'b1;
                    fin_seq = in_pga_data[111:80];
                    fin_ts  = in_pga_data[79:48];
                end
            end
            CHK: begin
                if (in_pga_valid_wr) fin = 1'b1;
            end
            default: ;
        endcase
    end

    // Modulo-2^32 subtract keeps latency correct across timestamp wrap.
    assign lat = in_pga_timestamp - fin_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            seq_q            <= '0;
            ts_q             <= '0;
            exp_seq          <= '0;
            out_pga_data     <= '0;
            out_pga_data_wr  <= 1'b0;
            out_pga_valid_wr <= 1'b0;
            out_pga_valid    <= 1'b0;
            out_pga_pkt_cnt  <= '0;
            out_pga_err_cnt  <= '0;
            out_pga_last_lat <= '0;
            out_pga_max_lat  <= '0;
        end else begin
            out_pga_data_wr  <= 1'b0;
            out_pga_valid_wr <= 1'b0;
            out_pga_valid    <= 1'b0;

            case (state)
                IDLE: begin
                    // Body/tail words without a preceding head are orphans.
                    if (head) begin
                        if (is_tag) begin
                            seq_q <= in_pga_data[111:80];
                            ts_q  <= in_pga_data[79:48];
                            if (!in_pga_valid_wr) state <= CHK;
                        end else begin
                            out_pga_data    <= in_pga_data;
                            out_pga_data_wr <= 1'b1;
                            if (in_pga_valid_wr) begin
                                out_pga_valid_wr <= 1'b1;
                                out_pga_valid    <= in_pga_valid;
                            end else begin
                                state <= FWD;
                            end
                        end
                    end
                end
                FWD: begin
                    if (in_pga_data_wr) begin
                        out_pga_data    <= in_pga_data;
                        out_pga_data_wr <= 1'b1;
                    end
                    if (in_pga_valid_wr) begin
                        out_pga_valid_wr <= 1'b1;
                        out_pga_valid    <= in_pga_valid;
                        state            <= IDLE;
                    end
                end
                CHK: begin
                    if (in_pga_valid_wr) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Start flag wins over a coincident end-of-packet update.
            if (in_pga_start_flag) begin
                out_pga_pkt_cnt  <= '0;
                out_pga_err_cnt  <= '0;
                out_pga_last_lat <= '0;
                out_pga_max_lat  <= '0;
                exp_seq          <= '0;
            end else if (fin) begin
                if (!in_pga_valid) begin
                    if (out_pga_err_cnt != '1) out_pga_err_cnt <= out_pga_err_cnt + 32'd1;
                end else begin
                    if (out_pga_pkt_cnt != '1) out_pga_pkt_cnt <= out_pga_pkt_cnt + 32'd1;
                    if ((fin_seq != exp_seq) && (out_pga_err_cnt != '1))
                        out_pga_err_cnt <= out_pga_err_cnt + 32'd1;
                    exp_seq          <= fin_seq + 32'd1;
                    out_pga_last_lat <= lat;
                    if (lat > out_pga_max_lat) out_pga_max_lat <= lat;
                end
            end
        end
    end

endmodule

// File: tb/tb_pga.sv
module tb_pga;

    logic         clk = 1'b0;
    logic         rst;
    logic [133:0] in_pga_data;
    logic         in_pga_data_wr;
    logic         in_pga_valid_wr;
    logic         in_pga_valid;
    logic         out_pga_alf;
    logic [31:0]  in_pga_timestamp;
    logic         in_pga_start_flag;
    logic [133:0] out_pga_data;
    logic         out_pga_data_wr;
    logic         out_pga_valid_wr;
    logic         out_pga_valid;
    logic         in_pga_alf;
    logic [31:0]  out_pga_pkt_cnt;
    logic [31:0]  out_pga_err_cnt;
    logic [31:0]  out_pga_last_lat;
    logic [31:0]  out_pga_max_lat;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Expected output entries: {data[133:0], valid_wr, valid}
    logic [135:0] sb [$];

    pga #(.TAG(16'hFA57), .LMID(8'd7)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_pga_data       (in_pga_data),
        .in_pga_data_wr    (in_pga_data_wr),
        .in_pga_valid_wr   (in_pga_valid_wr),
        .in_pga_valid      (in_pga_valid),
        .out_pga_alf       (out_pga_alf),
        .in_pga_timestamp  (in_pga_timestamp),
        .in_pga_start_flag (in_pga_start_flag),
        .out_pga_data      (out_pga_data),
        .out_pga_data_wr   (out_pga_data_wr),
        .out_pga_valid_wr  (out_pga_valid_wr),
        .out_pga_valid     (out_pga_valid),
        .in_pga_alf        (in_pga_alf),
        .out_pga_pkt_cnt   (out_pga_pkt_cnt),
        .out_pga_err_cnt   (out_pga_err_cnt),
        .out_pga_last_lat  (out_pga_last_lat),
        .out_pga_max_lat   (out_pga_max_lat)
    );

    always #5 clk = ~clk;

    // Monitor: every output strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (out_pga_data_wr || out_pga_valid_wr)) begin
            logic [135:0] e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got data=%h wr=%b vwr=%b v=%b, required no output",
                         out_pga_data, out_pga_data_wr, out_pga_valid_wr, out_pga_valid);
            end else begin
                e = sb.pop_front();
                if (out_pga_data !== e[135:2] || out_pga_data_wr !== 1'b1 ||
                    out_pga_valid_wr !== e[1] || out_pga_valid !== e[0]) begin
                    bad++;
                    $display("FAIL out_word: got data=%h wr=%b vwr=%b v=%b, required data=%h wr=1 vwr=%b v=%b",
                             out_pga_data, out_pga_data_wr, out_pga_valid_wr, out_pga_valid,
                             e[135:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] p, input logic [31:0] e,
                             input logic [31:0] l, input logic [31:0] m);
        chk({tag, ".pkt_cnt"},  out_pga_pkt_cnt,  p);
        chk({tag, ".err_cnt"},  out_pga_err_cnt,  e);
        chk({tag, ".last_lat"}, out_pga_last_lat, l);
        chk({tag, ".max_lat"},  out_pga_max_lat,  m);
    endtask

    // Drive one word for one cycle. Called at posedge+1, returns at posedge+1.
    task automatic word(input logic [1:0] typ, input logic [127:0] pay,
                        input logic vwr, input logic v, input logic fwd);
        in_pga_data     = {typ, 4'h0, pay};
        in_pga_data_wr  = 1'b1;
        in_pga_valid_wr = vwr;
        in_pga_valid    = v;
        if (fwd) sb.push_back({typ, 4'h0, pay, vwr, vwr & v});
        @(posedge clk); #1;
        in_pga_data_wr  = 1'b0;
        in_pga_valid_wr = 1'b0;
        in_pga_valid    = 1'b0;
    endtask

    // Two-word test packet: head {TAG, seq, tx_ts}, tail ends at rx timestamp.
    task automatic tpkt(input logic [31:0] seq, input logic [31:0] tx,
                        input logic [31:0] rx, input logic v);
        word(2'b01, {16'hFA57, seq, tx, 48'h0}, 1'b0, 1'b0, 1'b0);
        in_pga_timestamp = rx;
        word(2'b10, 128'h0, 1'b1, v, 1'b0);
    endtask

    task automatic start_pulse();
        in_pga_start_flag = 1'b1;
        @(posedge clk); #1;
        in_pga_start_flag = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_pga_data = '0;
        in_pga_data_wr = 1'b0;
        in_pga_valid_wr = 1'b0;
        in_pga_valid = 1'b0;
        in_pga_timestamp = '0;
        in_pga_start_flag = 1'b0;
        in_pga_alf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_data_wr",  {31'd0, out_pga_data_wr},  32'd0);
        chk("rst.out_valid_wr", {31'd0, out_pga_valid_wr}, 32'd0);
        chk("rst.out_data_lo",  out_pga_data[31:0], 32'd0);
        chk_stats("rst", 0, 0, 0, 0);
        in_pga_alf = 1'b1; #1;
        chk("alf.high", {31'd0, out_pga_alf}, 32'd1);
        in_pga_alf = 1'b0; #1;
        chk("alf.low", {31'd0, out_pga_alf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Ordinary traffic, 3 words, forwarded 1 cycle later.
        word(2'b01, {16'h1234, 112'h0123_4567_89AB_CDEF_0011_2233_4455}, 1'b0, 1'b0, 1'b1);
        word(2'b11, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0, 1'b0, 1'b1);
        word(2'b10, 128'hCAFE_F00D_6666_7777_8888_9999_AAAA_BBBB, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk_stats("fwd", 0, 0, 0, 0);

        // Good in-order test packets, latency 50.
        tpkt(0, 100, 150, 1'b1);
        tpkt(1, 100, 150, 1'b1);
        tpkt(2, 100, 150, 1'b1);
        chk_stats("inorder", 3, 0, 50, 50);

        // Sequence gap: 0,1,3,4 gives one error, exp_seq ends at 5.
        start_pulse();
        chk_stats("clear1", 0, 0, 0, 0);
        tpkt(0, 0, 10, 1'b1);
        tpkt(1, 0, 10, 1'b1);
        tpkt(3, 0, 10, 1'b1);
        tpkt(4, 0, 10, 1'b1);
        chk_stats("gap", 4, 1, 10, 10);
        // Single-word test packet seq 5 (matches exp_seq), latency 7.
        in_pga_timestamp = 207;
        word(2'b01, {16'hFA57, 32'd5, 32'd200, 48'h0}, 1'b1, 1'b1, 1'b0);
        chk_stats("single", 5, 1, 7, 10);

        // Timestamp wrap.
        start_pulse();
        tpkt(0, 32'hFFFF_FFF0, 32'h0000_0010, 1'b1);
        chk_stats("wrap", 1, 0, 32, 32);

        // Bad packet: only err_cnt moves.
        tpkt(1, 32'd500, 32'd900, 1'b0);
        chk_stats("badpkt", 1, 1, 32, 32);

        // Start flag coincident with valid_wr drops the update.
        word(2'b01, {16'hFA57, 32'd1, 32'd0, 48'h0}, 1'b0, 1'b0, 1'b0);
        in_pga_timestamp = 32'd99;
        in_pga_start_flag = 1'b1;
        word(2'b10, 128'h0, 1'b1, 1'b1, 1'b0);
        in_pga_start_flag = 1'b0;
        chk_stats("startcoinc", 0, 0, 0, 0);

        // Stats from a good packet, then reset mid test packet.
        tpkt(0, 0, 5, 1'b1);
        word(2'b01, {16'hFA57, 32'd1, 32'd0, 48'h0}, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        word(2'b11, 128'h1111, 1'b0, 1'b0, 1'b0);
        word(2'b10, 128'h2222, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_stats("midrst", 0, 0, 0, 0);
        // Next head is classified normally: single-word forward packet.
        word(2'b01, {16'h5555, 112'h77}, 1'b1, 1'b1, 1'b1);
        // Two-word forward packet discarded upstream (valid=0).
        word(2'b01, {16'hABCD, 112'h88}, 1'b0, 1'b0, 1'b1);
        word(2'b10, 128'h99, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb.drained", sb.size(), 32'd0);
        chk_stats("final", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pga.md
# pga

Packet generator analyzer: the receiving end of the packet generator (pgm) path. It sits at the pipeline egress, classifies each incoming 134-bit packet as a generated test packet or ordinary traffic, absorbs test packets while checking sequence order and one-way latency, and forwards ordinary traffic unchanged with one cycle of delay. Statistics are exposed as registered status ports, and the generator's start flag clears them.

## Interface
Parameters:
- TAG, 16'hFA57: marker expected in head word data[127:112] of generated packets.
- LMID, 8'd7: self module ID, carried for configuration-chain compatibility.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_pga_data  in  134  [133:132] 01 head / 11 body / 10 tail, [131:128] invalid-byte count, [127:0] payload
- in_pga_data_wr  in  1  data word strobe
- in_pga_valid_wr  in  1  end-of-packet strobe, coincident with the tail word
- in_pga_valid  in  1  1 = packet good, 0 = discard
- out_pga_alf  out  1  almost-full to upstream; equals in_pga_alf, combinational
- in_pga_timestamp  in  32  free-running cycle counter shared with pgm
- in_pga_start_flag  in  1  pgm sent-start pulse; clears statistics
- out_pga_data / out_pga_data_wr / out_pga_valid_wr / out_pga_valid  out  134/1/1/1  forwarded non-test traffic
- in_pga_alf  in  1  downstream almost-full
- out_pga_pkt_cnt  out  32  good test packets received
- out_pga_err_cnt  out  32  sequence errors plus bad (valid=0) test packets
- out_pga_last_lat  out  32  latency of the most recent good test packet
- out_pga_max_lat  out  32  maximum latency since clear

## Operation
- Head word format for test packets: data[127:112]=TAG, [111:80]=seq (32 bit), [79:48]=tx timestamp.
- FSM states:
  - IDLE: waits for a head word. If data[127:112]==TAG, latch seq and tx_ts, then go to CHK. Otherwise register the word to the output and go to FWD.
  - FWD: register every word to the output. On in_pga_valid_wr, register valid_wr/valid and return to IDLE.
  - CHK: absorb words, producing no output. On in_pga_valid_wr, update statistics and return to IDLE.
- A single-word packet (head and valid_wr in the same cycle) is finalized in that cycle. The FSM stays in IDLE.
- A body or tail word arriving in IDLE is dropped silently. The FSM stays in IDLE.
- Statistics update at end of a test packet:
  - valid=0: err_cnt+1. No other statistic changes.
  - valid=1: pkt_cnt+1. If seq≠exp_seq, err_cnt+1. exp_seq←seq+1 in both cases.
  - lat = in_pga_timestamp − tx_ts, computed modulo 2^32 (wrap-safe unsigned subtract). last_lat←lat; max_lat←max(max_lat, lat).
- Counters saturate at 32'hFFFFFFFF. exp_seq wraps.
- in_pga_start_flag: pkt_cnt, err_cnt, last_lat, max_lat and exp_seq are set to 0 next cycle.
  - It takes priority over a simultaneous end-of-packet update, which is lost.
  - The FSM is not disturbed.
- Reset mid-packet: FSM→IDLE. Remaining words of that packet are dropped as orphans (no head seen).

## Timing
- Reset values: every output 0 except out_pga_alf, which follows in_pga_alf.
- Forward latency: exactly 1 cycle, word for word, with no bubbles inserted.
- Statistics are visible the cycle after the valid_wr cycle.
- Upstream obeys out_pga_alf. The block has no internal buffering, so back-pressure is purely pass-through.

## Test plan
- Head with data[127:112]=16'h1234, 3 words, valid=1 → same 3 words plus valid_wr/valid=1 on the output, each 1 cycle later; statistics unchanged.
- Test packets with seq 0,1,2, tx_ts=100, valid_wr at timestamp 150 → pkt_cnt=3, err_cnt=0, last_lat=50, max_lat=50; no output strobes.
- Test packets with seq 0,1,3,4 → err_cnt=1, pkt_cnt=4, exp_seq=5.
- tx_ts=32'hFFFFFFF0, received at 32'h00000010 → last_lat=32.
- Test packet with valid=0 → err_cnt+1, pkt_cnt unchanged. Start flag coincident with valid_wr → all statistics 0.
- rst asserted after the head word of a test packet, then the remaining body/tail words → nothing output, statistics 0, next head is classified normally.
